// File: rtl/metro_pkg.sv
// Shared platform-sequencer definitions: state encodings and the state width that
// the station display decoder also relies on.
package metro_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ARRIVED = 3'd1;
  localparam state_t ST_DWELL   = 3'd2;
  localparam state_t ST_WARN    = 3'd3;
  localparam state_t ST_CLOSING = 3'd4;
  localparam state_t ST_DEPART  = 3'd5;
  localparam state_t ST_EMERG   = 3'd6;

endpackage

// File: rtl/tick_edge_det.sv
// One-clk tick on each rising edge of a slow square wave already in the clk domain.
module tick_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sq_in,
  output logic tick
);

  logic sq_d;

  // Reset loads the live level, so a wave that is already high at reset
  // release does not look like a fresh rising edge.
  always_ff @(posedge clk) begin
    if (rst) sq_d <= sq_in;
    else     sq_d <= sq_in;
  end

  assign tick = sq_in & ~sq_d;

endmodule

// File: rtl/platform_door_ctrl.sv
// Platform-side sequencer for one track: arrive, dwell, warn, close and depart timed
// in tenths of a second, with obstruction reopen and emergency stop.
module platform_door_ctrl
  import metro_pkg::*;
#(
  parameter int ARRIVE_T   = 10,
  parameter int DWELL_T    = 150,
  parameter int WARN_T     = 30,
  parameter int CLOSE_T    = 20,
  parameter int REOPEN_T   = 50,
  parameter int DEPART_T   = 20,
  parameter int MAX_REOPEN = 3,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_10Hz,
  input  logic               train_arrive,
  input  logic               obstruction,
  input  logic               emergency,
  input  logic               emerg_clr,
  output logic               door_open,
  output logic               door_closing,
  output logic               buzzer,
  output logic               depart_ok,
  output logic               fault,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   cnt_tenths
);

  localparam int RW = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);

  logic            tick;
  logic            expire;
  state_t          state_q, state_n;
  logic [CNT_W-1:0] cnt_q, cnt_n, cnt_dec;
  logic [RW-1:0]   reopen_q, reopen_n;
  logic            fault_q, fault_n;

  tick_edge_det u_tick (
    .clk   (clk),
    .rst   (rst),
    .sq_in (clk_10Hz),
    .tick  (tick)
  );

  assign expire  = tick && (cnt_q == CNT_W'(1));
  assign cnt_dec = tick ? (cnt_q - CNT_W'(1)) : cnt_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_n  = state_q;
    cnt_n    = cnt_q;
    reopen_n = reopen_q;
    fault_n  = fault_q;

    if (emergency) begin
      state_n = ST_EMERG;
      cnt_n   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          cnt_n = '0;
          if (train_arrive) begin
            state_n  = ST_ARRIVED;
            cnt_n    = CNT_W'(ARRIVE_T);
            reopen_n = '0;
          end
        end
        ST_ARRIVED: begin
          cnt_n = cnt_dec;
          if (expire) begin
            state_n = ST_DWELL;
            cnt_n   = CNT_W'(DWELL_T);
          end
        end
        ST_DWELL: begin
          cnt_n = cnt_dec;
          if (expire) begin
            state_n = ST_WARN;
            cnt_n   = CNT_W'(WARN_T);
          end
        end
        ST_WARN: begin
          cnt_n = cnt_dec;
          if (expire) begin
            state_n = ST_CLOSING;
            cnt_n   = CNT_W'(CLOSE_T);
          end
        end
        ST_CLOSING: begin
          cnt_n = cnt_dec;
          // Obstruction outranks expiry, so a blocked edge on the last tick reopens.
          if (obstruction) begin
            if (reopen_q < RW'(MAX_REOPEN)) begin
              state_n  = ST_DWELL;
              cnt_n    = CNT_W'(REOPEN_T);
              reopen_n = reopen_q + RW'(1);
            end else begin
              state_n = ST_EMERG;
              cnt_n   = '0;
              fault_n = 1'b1;
            end
          end else if (expire) begin
            state_n = ST_DEPART;
            cnt_n   = CNT_W'(DEPART_T);
          end
        end
        ST_DEPART: begin
          cnt_n = cnt_dec;
          if (expire) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_EMERG: begin
          cnt_n = '0;
          if (emerg_clr) begin
            state_n = ST_IDLE;
            fault_n = 1'b0;
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      reopen_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      reopen_q <= reopen_n;
      fault_q  <= fault_n;
    end
  end

  // Moore decode: EMERG keeps the buzzer on but drops every door command.
  assign door_open    = (state_q == ST_DWELL) || (state_q == ST_WARN) || (state_q == ST_CLOSING);
  assign door_closing = (state_q == ST_CLOSING);
  assign buzzer       = (state_q == ST_WARN) || (state_q == ST_CLOSING) || (state_q == ST_EMERG);
  assign depart_ok    = (state_q == ST_DEPART);
  assign fault        = fault_q;
  assign state        = state_q;
  assign cnt_tenths   = cnt_q;

endmodule

// File: tb/tb_platform_door_ctrl.sv
// Directed bench for platform_door_ctrl: a nominal-cycle vector table plus
// hand-written reopen, fault, emergency, reset and tick-boundary sequences.
module tb_platform_door_ctrl;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARR = 3'd1, S_DWELL = 3'd2, S_WARN = 3'd3,
                         S_CLOSE = 3'd4, S_DEP = 3'd5, S_EMERG = 3'd6;

  logic       clk = 1'b0, rst = 1'b1, clk_10Hz = 1'b0;
  logic       train_arrive = 1'b0, obstruction = 1'b0, emergency = 1'b0, emerg_clr = 1'b0;
  logic       door_open, door_closing, buzzer, depart_ok, fault;
  logic [2:0] state;
  logic [7:0] cnt_tenths;

  int n_pass = 0;
  int n_total = 0;

  platform_door_ctrl #(
    .ARRIVE_T(2), .DWELL_T(3), .WARN_T(2), .CLOSE_T(2), .REOPEN_T(2), .DEPART_T(2),
    .MAX_REOPEN(1), .CNT_W(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .clk_10Hz     (clk_10Hz),
    .train_arrive (train_arrive),
    .obstruction  (obstruction),
    .emergency    (emergency),
    .emerg_clr    (emerg_clr),
    .door_open    (door_open),
    .door_closing (door_closing),
    .buzzer       (buzzer),
    .depart_ok    (depart_ok),
    .fault        (fault),
    .state        (state),
    .cnt_tenths   (cnt_tenths)
  );

  always #5 clk = ~clk;

  // Toggles every 5 clk; rising edges land 3 ns before a clk posedge.
  initial begin
    #2;
    forever #50 clk_10Hz = ~clk_10Hz;
  end

  typedef struct {
    logic       arrive, obstr, emerg, clr, adv;
    logic [2:0] st;
    logic [7:0] cnt;
    logic [4:0] outs;  // {door_open, door_closing, buzzer, depart_ok, fault}
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [7:0] c,
                           input logic [4:0] o);
    check({tag, " state"}, 32'(state), 32'(st));
    check({tag, " cnt"}, 32'(cnt_tenths), 32'(c));
    check({tag, " outs"}, 32'({door_open, door_closing, buzzer, depart_ok, fault}), 32'(o));
  endtask

  // Drive inputs at a negedge for one clk; pulses drop, emergency level stays.
  task automatic step(input logic a, input logic o, input logic e, input logic c);
    train_arrive = a;
    obstruction  = o;
    emergency    = e;
    emerg_clr    = c;
    @(negedge clk);
    train_arrive = 1'b0;
    obstruction  = 1'b0;
    emerg_clr    = 1'b0;
  endtask

  task automatic tick_wait();
    @(posedge clk_10Hz);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_closing(input string tag);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) tick_wait();
    check_all({tag, " closing"}, S_CLOSE, 8'd2, 5'b11100);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, S_ARR,   8'd2, 5'b00000};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_ARR,   8'd1, 5'b00000};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_DWELL, 8'd3, 5'b10000};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, S_DWELL, 8'd2, 5'b10000};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_DWELL, 8'd1, 5'b10000};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_WARN,  8'd2, 5'b10100};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_WARN,  8'd1, 5'b10100};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_CLOSE, 8'd2, 5'b11100};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_CLOSE, 8'd1, 5'b11100};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_DEP,   8'd2, 5'b00010};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_DEP,   8'd1, 5'b00010};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, S_IDLE,  8'd0, 5'b00000};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_IDLE,  8'd0, 5'b00000};

    repeat (3) @(negedge clk);
    check_all("reset", S_IDLE, 8'd0, 5'b00000);
    rst = 1'b0;

    // Nominal cycle; vector 3 also shows arrive/obstruction ignored in DWELL.
    for (int i = 0; i < 13; i++) begin
      step(vecs[i].arrive, vecs[i].obstr, vecs[i].emerg, vecs[i].clr);
      if (vecs[i].adv) tick_wait();
      check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].cnt, vecs[i].outs);
    end

    // Reopen, then a clean close reaches DEPART and IDLE.
    run_to_closing("reopen");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("reopen dwell", S_DWELL, 8'd2, 5'b10000);
    repeat (6) tick_wait();
    check_all("reopen depart", S_DEP, 8'd2, 5'b00010);
    repeat (2) tick_wait();
    check_all("reopen idle", S_IDLE, 8'd0, 5'b00000);

    // Reopen limit: fresh cycle allows one reopen, the second obstruction faults.
    run_to_closing("limit");
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("limit reopen", S_DWELL, 8'd2, 5'b10000);
    repeat (4) tick_wait();
    check_all("limit closing2", S_CLOSE, 8'd2, 5'b11100);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    check_all("limit fault", S_EMERG, 8'd0, 5'b00101);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_all("limit clear", S_IDLE, 8'd0, 5'b00000);

    // Emergency beats obstruction; clear is ignored while emergency is held.
    run_to_closing("emerg");
    step(1'b0, 1'b1, 1'b1, 1'b0);
    check_all("emerg entry", S_EMERG, 8'd0, 5'b00100);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check_all("emerg clr held", S_EMERG, 8'd0, 5'b00100);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check_all("emerg dropped", S_EMERG, 8'd0, 5'b00100);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check_all("emerg clear", S_IDLE, 8'd0, 5'b00000);

    // Reset in WARN while clk_10Hz is high: no tick until its next rising edge.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (5) tick_wait();
    check_all("rst warn", S_WARN, 8'd2, 5'b10100);
    check("rst wave high", 32'(clk_10Hz), 32'd1);
    do_reset();
    check_all("rst idle", S_IDLE, 8'd0, 5'b00000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check_all("rst no tick", S_ARR, 8'd2, 5'b00000);
    tick_wait();
    check_all("rst first tick", S_ARR, 8'd1, 5'b00000);
    tick_wait();
    check_all("rst dwell", S_DWELL, 8'd3, 5'b10000);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check_all("arrive in dwell", S_DWELL, 8'd3, 5'b10000);
    do_reset();

    // Obstruction on the same clk as the final CLOSING tick reopens.
    run_to_closing("edge");
    tick_wait();
    check_all("edge cnt1", S_CLOSE, 8'd1, 5'b11100);
    @(posedge clk_10Hz);
    obstruction = 1'b1;
    @(negedge clk);
    obstruction = 1'b0;
    check_all("edge reopen", S_DWELL, 8'd2, 5'b10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
